// File: rtl/trap_ctrl_nirq.sv
// trap_ctrl_nirq: machine-mode trap controller with exceptions, synchronised
// level/edge interrupts, vectored mtvec, and the trap CSRs
// mtvec/mepc/mcause/mie/mip.
module trap_ctrl_nirq #(
   parameter int                N           = 64,
   parameter int                NUM_EXC     = 16,
   parameter int                NUM_IRQ     = 16,
   parameter int                SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0] IRQ_EDGE   = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EXC-1:0] exceptSignal,
   input  logic [NUM_IRQ-1:0] irqIn,
   input  logic               MIE,
   input  logic [N-1:0]       PC_F,
   input  logic               trapReturn,
   input  logic               CSR_WriteEnable,
   input  logic [11:0]        CSR_addr,
   input  logic [N-1:0]       CSR_In,
   output logic               trapTrigger,
   output logic               trapIsIrq,
   output logic [N-1:0]       trapTarget,
   output logic [N-1:0]       CSR_readData,
   output logic [N-1:0]       mtvec,
   output logic [N-1:0]       mepc,
   output logic [N-1:0]       mcause
);

   localparam logic [11:0] ADDR_MIE    = 12'h304;
   localparam logic [11:0] ADDR_MTVEC  = 12'h305;
   localparam logic [11:0] ADDR_MEPC   = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE = 12'h342;
   localparam logic [11:0] ADDR_MIP    = 12'h344;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] mie_q;
   logic [N-1:0]       mtvec_q;
   logic [N-1:0]       mepc_q;
   logic [N-1:0]       mcause_q;
   logic               holdoff;

   // ---------------------------------------------------------------------
   // Combinational nets
   // ---------------------------------------------------------------------
   logic               wr_mtvec;
   logic               wr_mepc;
   logic               wr_mcause;
   logic               wr_mie;
   logic               wr_mip;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] pend_clr;
   logic [NUM_IRQ-1:0] mip_v;
   logic [NUM_IRQ-1:0] irq_pending;
   logic [N-1:0]       exc_cause;
   logic [N-1:0]       irq_cause;
   logic [N-1:0]       cause;
   logic               exc_any;
   logic               irq_take;
   logic               trap_trig;
   logic               trap_irq;
   logic [1:0]         mtvec_mode_next;
   logic [N-1:0]       base_addr;
   logic [N-1:0]       vec_addr;
   logic [N-1:0]       target_raw;
   logic [N-1:0]       read_raw;
   logic [N-1:0]       mcause_next;

   // CSR write decode; unknown addresses decode to nothing
   assign wr_mtvec  = CSR_WriteEnable && (CSR_addr == ADDR_MTVEC);
   assign wr_mepc   = CSR_WriteEnable && (CSR_addr == ADDR_MEPC);
   assign wr_mcause = CSR_WriteEnable && (CSR_addr == ADDR_MCAUSE);
   assign wr_mie    = CSR_WriteEnable && (CSR_addr == ADDR_MIE);
   assign wr_mip    = CSR_WriteEnable && (CSR_addr == ADDR_MIP);

   // Bring each asynchronous interrupt line into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= irqIn;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign irq_s = sync_q[SYNC_STAGES-1];

   // Edge lines latch a rising edge of the synchronised level; software
   // clears by writing 0 to the mip bit, and a coincident new edge wins.
   assign irq_rise = irq_s & ~irq_prev & IRQ_EDGE;
   assign pend_clr = wr_mip ? (~CSR_In[NUM_IRQ-1:0] & IRQ_EDGE) : '0;

   // Track previous synchronised level and the edge-pending latches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_prev <= '0;
         pend     <= '0;
      end else begin
         irq_prev <= irq_s;
         pend     <= (pend & ~pend_clr) | irq_rise;
      end
   end

   // Level lines show the synchronised input directly, edge lines the latch
   assign mip_v       = (pend & IRQ_EDGE) | (irq_s & ~IRQ_EDGE);
   assign irq_pending = mie_q & mip_v;

   // Lowest-numbered exception is the cause
   always_comb begin
      exc_cause = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (exceptSignal[i]) exc_cause = N'(i);
      end
   end

   // Highest-numbered enabled pending interrupt is the cause
   always_comb begin
      irq_cause = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (irq_pending[i]) irq_cause = N'(i);
      end
   end

   // Exceptions bypass the global enable and the post-trap holdoff
   assign exc_any   = |exceptSignal;
   assign irq_take  = !exc_any && MIE && !holdoff && (|irq_pending);
   assign trap_trig = exc_any || irq_take;
   assign trap_irq  = irq_take;
   assign cause     = exc_any ? exc_cause : irq_cause;

   assign base_addr = {mtvec_q[N-1:2], 2'b00};
   assign vec_addr  = base_addr + (cause << 2);

   // Redirect target: trap entry (vectored only for interrupts), else mret
   always_comb begin
      target_raw = '0;
      if (trap_trig) begin
         if ((mtvec_q[1:0] == 2'b01) && trap_irq) target_raw = vec_addr;
         else                                     target_raw = base_addr;
      end else if (trapReturn) begin
         target_raw = mepc_q;
      end
   end

   // Unsupported MODE encodings leave the current mode in place
   assign mtvec_mode_next = (CSR_In[1:0] <= 2'b01) ? CSR_In[1:0] : mtvec_q[1:0];
   assign mcause_next     = {trap_irq, {(N-1){1'b0}}} | cause;

   // mtvec and mie follow software writes even in a trap cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtvec_q <= '0;
         mie_q   <= '0;
      end else begin
         if (wr_mtvec) mtvec_q <= {CSR_In[N-1:2], mtvec_mode_next};
         if (wr_mie)   mie_q   <= CSR_In[NUM_IRQ-1:0];
      end
   end

   // mepc/mcause capture trap state, overriding a coincident software write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (trap_trig) begin
         mepc_q   <= {PC_F[N-1:2], 2'b00};
         mcause_q <= mcause_next;
      end else begin
         if (wr_mepc)   mepc_q   <= {CSR_In[N-1:2], 2'b00};
         if (wr_mcause) mcause_q <= CSR_In;
      end
   end

   // One-cycle interrupt blackout after any trap while the pipeline flushes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) holdoff <= 1'b0;
      else        holdoff <= trap_trig;
   end

   // CSR read mux; narrow CSRs are zero-extended
   always_comb begin
      read_raw = '0;
      case (CSR_addr)
         ADDR_MTVEC:  read_raw = mtvec_q;
         ADDR_MEPC:   read_raw = mepc_q;
         ADDR_MCAUSE: read_raw = mcause_q;
         ADDR_MIE:    read_raw = N'(mie_q);
         ADDR_MIP:    read_raw = N'(mip_v);
         default:     read_raw = '0;
      endcase
   end

   // Combinational outputs are forced low while reset is held so the
   // datapath never sees a redirect from a core that is being reset.
   assign trapTrigger  = reset && trap_trig;
   assign trapIsIrq    = reset && trap_trig && trap_irq;
   assign trapTarget   = reset ? target_raw : '0;
   assign CSR_readData = reset ? read_raw : '0;
   assign mtvec        = mtvec_q;
   assign mepc         = mepc_q;
   assign mcause       = mcause_q;

endmodule

// File: tb/tb_trap_ctrl_nirq.sv
// Self-checking bench for trap_ctrl_nirq: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_trap_ctrl_nirq;

   localparam int N  = 64;
   localparam int NE = 16;
   localparam int NI = 16;
   localparam int SS = 2;
   localparam logic [NI-1:0] EDGE_MASK = 16'h0008;

   logic          clk = 1'b0;
   logic          reset;
   logic [NE-1:0] exceptSignal;
   logic [NI-1:0] irqIn;
   logic          MIE;
   logic [N-1:0]  PC_F;
   logic          trapReturn;
   logic          CSR_WriteEnable;
   logic [11:0]   CSR_addr;
   logic [N-1:0]  CSR_In;
   logic          trapTrigger;
   logic          trapIsIrq;
   logic [N-1:0]  trapTarget;
   logic [N-1:0]  CSR_readData;
   logic [N-1:0]  mtvec;
   logic [N-1:0]  mepc;
   logic [N-1:0]  mcause;

   always #5 clk = ~clk;

   trap_ctrl_nirq #(
      .N(N), .NUM_EXC(NE), .NUM_IRQ(NI), .SYNC_STAGES(SS), .IRQ_EDGE(EDGE_MASK)
   ) dut (
      .clk(clk), .reset(reset), .exceptSignal(exceptSignal), .irqIn(irqIn),
      .MIE(MIE), .PC_F(PC_F), .trapReturn(trapReturn),
      .CSR_WriteEnable(CSR_WriteEnable), .CSR_addr(CSR_addr), .CSR_In(CSR_In),
      .trapTrigger(trapTrigger), .trapIsIrq(trapIsIrq), .trapTarget(trapTarget),
      .CSR_readData(CSR_readData), .mtvec(mtvec), .mepc(mepc), .mcause(mcause)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [63:0] m_mtvec, m_mepc, m_mcause;
   logic [15:0] m_mie, m_pend;
   logic        m_hold;
   logic [15:0] hist [0:SS];   // hist[0] = irqIn sampled at the latest edge

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mtvec = '0; m_mepc = '0; m_mcause = '0;
      m_mie = '0; m_pend = '0; m_hold = 1'b0;
      for (int k = 0; k <= SS; k++) hist[k] = '0;
   endtask

   // irqIn delayed by SS edges is the synchronised level
   function automatic logic [15:0] m_mip();
      return (m_pend & EDGE_MASK) | (hist[SS-1] & ~EDGE_MASK);
   endfunction

   function automatic logic [63:0] m_read(input logic [11:0] a);
      case (a)
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h304: return {48'b0, m_mie};
         12'h344: return {48'b0, m_mip()};
         default: return 64'h0;
      endcase
   endfunction

   task automatic model_comb(output logic trig, output logic irq,
                             output logic [63:0] cause, output logic [63:0] tgt);
      logic [31:0] e, p;
      logic [63:0] base;
      e = {16'b0, exceptSignal};
      p = {16'b0, m_mie & m_mip()};
      trig = 1'b0; irq = 1'b0; cause = '0;
      if (e != 0) begin
         trig  = 1'b1;
         cause = 64'($clog2(e & (~e + 32'd1)));
      end else if (MIE && !m_hold && p != 0) begin
         trig  = 1'b1;
         irq   = 1'b1;
         cause = 64'($clog2(p + 32'd1) - 1);
      end
      base = m_mtvec & ~64'h3;
      if (trig)            tgt = (m_mtvec[1:0] == 2'b01 && irq) ? base + 4 * cause : base;
      else if (trapReturn) tgt = m_mepc;
      else                 tgt = '0;
   endtask

   task automatic model_update();
      logic t, q;
      logic [63:0] c, tg;
      logic [15:0] clr, rise;
      model_comb(t, q, c, tg);
      clr  = '0;
      rise = hist[SS-1] & ~hist[SS] & EDGE_MASK;
      if (CSR_WriteEnable) begin
         case (CSR_addr)
            12'h305: m_mtvec  = {CSR_In[63:2], (CSR_In[1:0] < 2'd2) ? CSR_In[1:0] : m_mtvec[1:0]};
            12'h341: m_mepc   = CSR_In & ~64'h3;
            12'h342: m_mcause = CSR_In;
            12'h304: m_mie    = CSR_In[15:0];
            12'h344: clr      = EDGE_MASK & ~CSR_In[15:0];
            default: ;
         endcase
      end
      m_pend = (m_pend & ~clr) | rise;
      if (t) begin
         m_mepc   = PC_F & ~64'h3;
         m_mcause = {q, 63'(c)};
      end
      m_hold = t;
      for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irqIn;
   endtask

   task automatic check_all(input string ctx);
      logic t, q;
      logic [63:0] c, tg, rd;
      model_comb(t, q, c, tg);
      rd = m_read(CSR_addr);
      if (!reset) begin
         t = 1'b0; q = 1'b0; tg = '0; rd = '0;
      end
      check({ctx, ".trig"},   64'(trapTrigger), 64'(t));
      check({ctx, ".isirq"},  64'(trapIsIrq),   64'(q));
      check({ctx, ".target"}, trapTarget,       tg);
      check({ctx, ".rdata"},  CSR_readData,     rd);
      check({ctx, ".mtvec"},  mtvec,            m_mtvec);
      check({ctx, ".mepc"},   mepc,             m_mepc);
      check({ctx, ".mcause"}, mcause,           m_mcause);
   endtask

   task automatic settle(input string ctx);
      #2;
      check_all(ctx);
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) model_update();
      @(negedge clk);
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
      CSR_WriteEnable = 1'b1; CSR_addr = a; CSR_In = d;
   endtask

   task automatic csr_rd(input logic [11:0] a);
      CSR_WriteEnable = 1'b0; CSR_addr = a; CSR_In = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; exceptSignal = 16'h0001; irqIn = '0; MIE = 1'b1;
      PC_F = 64'h1234; trapReturn = 1'b1; CSR_WriteEnable = 1'b0;
      CSR_addr = 12'h305; CSR_In = '0;
      model_reset();
      @(negedge clk);

      // Reset state: outputs low despite an active exception request
      settle("rst");
      check("rst.trig_const", 64'(trapTrigger), 64'h0);
      advance();

      // Vectored interrupt on level line 11
      reset = 1'b1; exceptSignal = '0; trapReturn = 1'b0; MIE = 1'b0;
      csr_wr(12'h305, 64'h1001); settle("tp1.w_mtvec"); advance();
      csr_wr(12'h304, 64'h0800); settle("tp1.w_mie");   advance();
      csr_rd(12'h342); MIE = 1'b1; irqIn = 16'h0800; PC_F = 64'h8000_1237;
      settle("tp1.c0"); advance();
      settle("tp1.c1"); advance();
      settle("tp1.c2");
      check("tp1.trig_const",   64'(trapTrigger), 64'h1);
      check("tp1.isirq_const",  64'(trapIsIrq),   64'h1);
      check("tp1.target_const", trapTarget,       64'h102C);
      advance();
      settle("tp1.c3");
      check("tp1.mcause_const",  mcause,            64'h8000_0000_0000_000B);
      check("tp1.mepc_const",    mepc,              64'h8000_1234);
      check("tp1.holdoff_const", 64'(trapTrigger),  64'h0);
      advance();

      // Exception beats a pending interrupt
      exceptSignal = 16'h0104;
      settle("tp2");
      check("tp2.trig_const",   64'(trapTrigger), 64'h1);
      check("tp2.isirq_const",  64'(trapIsIrq),   64'h0);
      check("tp2.target_const", trapTarget,       64'h1000);
      advance();
      exceptSignal = '0; MIE = 1'b0; irqIn = '0;
      settle("tp2.after"); advance();

      // Edge line 3: pulse, latch, clear, set-wins-over-clear
      csr_rd(12'h344); irqIn = 16'h0008;
      settle("tp3.p0"); advance();
      irqIn = '0;
      settle("tp3.p1"); advance();
      settle("tp3.p2"); advance();
      settle("tp3.p3");
      check("tp3.latched", 64'(CSR_readData[3]), 64'h1);
      advance();
      settle("tp3.p4");
      check("tp3.held", 64'(CSR_readData[3]), 64'h1);
      csr_wr(12'h344, 64'h0); settle("tp3.clr"); advance();
      csr_rd(12'h344); settle("tp3.clrd");
      check("tp3.cleared", 64'(CSR_readData[3]), 64'h0);
      irqIn = 16'h0008; settle("tp3.q0"); advance();
      irqIn = '0;       settle("tp3.q1"); advance();
      csr_wr(12'h344, 64'h0); settle("tp3.q2"); advance();
      csr_rd(12'h344); settle("tp3.q3");
      check("tp3.setwins", 64'(CSR_readData[3]), 64'h1);
      csr_wr(12'h344, 64'h0); settle("tp3.q4"); advance();

      // mtvec MODE retention, mepc alignment, unmapped read
      csr_wr(12'h305, 64'h2003); settle("tp4.w"); advance();
      csr_rd(12'h305); settle("tp4.r");
      check("tp4.mtvec_const", CSR_readData, 64'h2001);
      csr_wr(12'h341, 64'h47); settle("tp4.we"); advance();
      csr_rd(12'h341); settle("tp4.re");
      check("tp4.mepc_const", CSR_readData, 64'h44);
      csr_rd(12'h7FF); settle("tp4.unmapped");
      check("tp4.unmapped_const", CSR_readData, 64'h0);

      // mret alone
      csr_rd(12'h341); trapReturn = 1'b1;
      settle("tp5.ret");
      check("tp5.target_const", trapTarget, 64'h44);
      advance();
      trapReturn = 1'b0; settle("tp5.after");
      check("tp5.mepc_const", mepc, 64'h44);

      // Level interrupt held: trap, holdoff, trap again
      irqIn = 16'h0800; MIE = 1'b1; PC_F = 64'hABCD_0006;
      settle("tp6.s0"); advance();
      settle("tp6.s1"); advance();
      settle("tp6.t0");
      check("tp6.trig_const", 64'(trapTrigger), 64'h1);
      advance();
      settle("tp6.t1");
      check("tp6.hold_const", 64'(trapTrigger), 64'h0);
      advance();
      settle("tp6.t2");

      // Reset asserted in the middle of a trap cycle
      #1; reset = 1'b0; model_reset();
      #1; check_all("tp7.inrst");
      check("tp7.trig_const",   64'(trapTrigger), 64'h0);
      check("tp7.target_const", trapTarget,       64'h0);
      advance();
      reset = 1'b1; irqIn = '0; MIE = 1'b0;
      csr_rd(12'h342); settle("tp7.mcause");
      check("tp7.mcause_const", CSR_readData, 64'h0);
      csr_rd(12'h341); settle("tp7.mepc");
      csr_rd(12'h305); settle("tp7.mtvec");
      check("tp7.mtvec_const", CSR_readData, 64'h0);
      advance();

      // Randomized traffic against the model
      for (int c = 0; c < 500; c++) begin
         logic [11:0] addrs [6];
         addrs = '{12'h305, 12'h341, 12'h342, 12'h304, 12'h344, 12'h7FF};
         exceptSignal = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
         if ($urandom_range(0, 3) == 0) irqIn = 16'($urandom);
         MIE             = ($urandom_range(0, 3) != 0);
         trapReturn      = ($urandom_range(0, 5) == 0);
         PC_F            = {$urandom, $urandom};
         CSR_WriteEnable = ($urandom_range(0, 2) == 0);
         CSR_addr        = addrs[$urandom_range(0, 5)];
         CSR_In          = {$urandom, $urandom};
         if (CSR_addr == 12'h305 && $urandom_range(0, 1) == 0)
            CSR_In = 64'($urandom_range(0, 16'hFFFF));
         settle("rnd");
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trap_ctrl_nirq.md
Name: trap_ctrl_nirq

Overview:
- Parametrised successor to the core's exception controller. Adds real interrupt support: NUM_IRQ asynchronous interrupt lines, per-line level/edge mode, and vectored mtvec.
- Owns the trap CSRs mtvec, mepc, mcause, mie and mip.
- Produces the trap redirect target and the trap pulse consumed by the datapath and the status unit.
- Sits beside the datapath, driven by the same CSR write bus.

Parameters:
N, 64, data/CSR width
NUM_EXC, 16, exception request lines; cause code = bit index
NUM_IRQ, 16, interrupt lines; cause code = bit index (NUM_IRQ <= N-1)
SYNC_STAGES, 2, synchroniser depth on irqIn (>=2)
IRQ_EDGE, {NUM_IRQ{1'b0}}, per-line mode mask: 1 = rising-edge latched, 0 = level

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
exceptSignal  in  NUM_EXC  exception requests, current cycle, one-hot or multi-hot
irqIn  in  NUM_IRQ  external interrupt lines, asynchronous to clk
MIE  in  1  mstatus.MIE global enable
PC_F  in  N  PC of the instruction being trapped
trapReturn  in  1  mret in current cycle
CSR_WriteEnable  in  1  CSR write strobe
CSR_addr  in  12  CSR address
CSR_In  in  N  CSR write data
trapTrigger  out  1  trap taken this cycle
trapIsIrq  out  1  taken trap is an interrupt
trapTarget  out  N  redirect PC when trapTrigger or trapReturn
CSR_readData  out  N  read mux of owned CSRs
mtvec, mepc, mcause  out  N  direct CSR views

Behaviour:
- Reset (reset low, async): mtvec, mepc, mcause, mie, edge-pending and sync chains clear to 0. Holdoff flag clears to 0. All outputs are 0.
- CSR addresses:
  - 0x305 mtvec
  - 0x341 mepc
  - 0x342 mcause
  - 0x304 mie (bits NUM_IRQ-1:0 writable, rest read 0)
  - 0x344 mip
- Any other address reads 0, and writes to it are ignored.
- Writes take effect at the next posedge clk and are readable the cycle after.
- mtvec write:
  - BASE = CSR_In[N-1:2].
  - MODE = CSR_In[1:0] only if CSR_In[1:0] is 0 or 1; otherwise MODE keeps its old value.
- mepc write stores CSR_In with bits [1:0] forced to 0.
- Interrupt synchronisation: each irqIn bit passes through a SYNC_STAGES flop chain, giving s[i].
- Level line (IRQ_EDGE[i]=0):
  - mip[i] = s[i].
  - Writes to mip[i] are ignored.
- Edge line (IRQ_EDGE[i]=1):
  - A flop records s[i] of the previous cycle.
  - A 0->1 transition sets pend[i].
  - A write of 0 to mip[i] clears pend[i]; a write of 1 has no effect.
  - Set and clear in the same cycle: set wins.
  - mip[i] = pend[i].
- Latency: irqIn rise to mip visible = SYNC_STAGES cycles for level lines, SYNC_STAGES+1 for edge lines.
- Trap selection (combinational, current cycle):
  - Exception takes priority if any exceptSignal bit is set. The lowest set index is the cause; trapIsIrq = 0.
  - Otherwise an interrupt is taken if MIE=1, holdoff=0, and (mie & mip) != 0. The highest set index is the cause; trapIsIrq = 1.
  - Exceptions ignore MIE and holdoff.
  - trapTrigger = exception or interrupt taken.
- On the clk edge where trapTrigger=1:
  - mepc <= {PC_F[N-1:2], 2'b00}.
  - mcause <= {trapIsIrq, zero-pad, cause}; bit N-1 is the interrupt flag.
  - holdoff <= 1 for exactly one cycle, which blocks back-to-back interrupts during the pipeline flush.
  - Trap updates override a same-cycle CSR write to mepc/mcause. A same-cycle write to mtvec/mie still applies.
  - pend bits are not auto-cleared; software clears them.
- trapTarget:
  - trapTrigger with MODE=0: {BASE, 2'b00}.
  - trapTrigger with MODE=1 and interrupt: {BASE, 2'b00} + 4*cause, computed mod 2^N.
  - trapTrigger with MODE=1 and exception: {BASE, 2'b00}.
  - trapReturn without trapTrigger: mepc.
  - Otherwise: 0.
- trapReturn and trapTrigger in the same cycle: the trap wins and mepc is overwritten.
- Reset asserted mid-operation clears everything immediately. Any in-flight pending edges are lost.

Test Plan:
- Reset, then write mtvec=0x1001 (MODE 1), mie=0x800, MIE=1, raise irqIn[11] -> after 2 cycles trapTrigger=1, trapIsIrq=1, trapTarget=0x102C; next edge mcause=0x800...000B, mepc=PC_F&~3.
- exceptSignal=0x0104 with irq 11 also pending -> cause 2, trapIsIrq=0, trapTarget=0x1000 (MODE 1, exception); interrupt not taken that cycle.
- IRQ_EDGE[3]=1: pulse irqIn[3] high one cycle -> mip[3]=1 after 3 cycles and stays 1; write mip=0 -> mip[3]=0 next cycle; a new edge arriving in the clear cycle -> mip[3] remains 1.
- Write mtvec=0x2003 after mtvec=0x1001 -> reads 0x2001 (MODE retained, BASE updated); write mepc=0x47 -> reads 0x44; read 0x7FF -> 0.
- Level irq held with MIE=1: trapTrigger cycle t, cycle t+1 trapTrigger=0 (holdoff) even if MIE still 1; trapReturn alone -> trapTarget=mepc, no CSR change.
- Assert reset low mid-trap cycle -> all outputs 0 immediately, mcause/mepc/mtvec read 0 after release.
